// File: rtl/axi_txn_scheduler_pkg.sv
// Shared types and widths for the AXI transaction scheduler.
package axi_txn_sched_pkg;

    localparam int COUNT_W  = 16;
    localparam int CH_IDX_W = 3;

    // Scheduler control states; exactly one is active at a time.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_PULSE,
        ST_WAIT,
        ST_FINISH
    } sched_state_t;

endpackage

// File: rtl/axi_txn_scheduler_if.sv
// Engine-side bus between the scheduler and its AXI master test engines.
interface axi_txn_scheduler_if #(
    parameter int NUM_CH = 2
);

    logic [NUM_CH-1:0] init_axi_txn;
    logic [NUM_CH-1:0] txn_done;
    logic [NUM_CH-1:0] txn_error;

    // Scheduler side: fires init pulses, watches done/error levels.
    modport master (
        output init_axi_txn,
        input  txn_done,
        input  txn_error
    );

    // Engine side: receives init pulses, reports done/error levels.
    modport slave (
        input  init_axi_txn,
        output txn_done,
        output txn_error
    );

endinterface

// File: rtl/axi_txn_scheduler_rr_next_sel.sv
// Round-robin next-channel picker: first enabled channel after last_idx,
// wrapping at NUM_CH. Holds last_idx when no channel is enabled.
module rr_next_sel
    import axi_txn_sched_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic [NUM_CH-1:0]   en_mask,
    input  logic [CH_IDX_W-1:0] last_idx,
    output logic [CH_IDX_W-1:0] next_idx
);

    logic                found;
    logic [CH_IDX_W-1:0] cand;

    // Scan forward from last_idx+1, keeping the first enabled candidate.
    always_comb begin
        next_idx = last_idx;
        found    = 1'b0;
        cand     = '0;
        for (int off = 1; off <= NUM_CH; off++) begin
            cand = CH_IDX_W'((int'(last_idx) + off) % NUM_CH);
            if (!found && ((en_mask & (NUM_CH'(1) << cand)) != '0)) begin
                next_idx = cand;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_txn_scheduler.sv
// Sequences init pulses to NUM_CH AXI master test engines in round-robin
// order, counts pass/error completions and aborts a run on timeout.
module axi_txn_scheduler
    import axi_txn_sched_pkg::*;
#(
    parameter int NUM_CH            = 2,
    parameter int INIT_PULSE_CYCLES = 2
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                start,
    input  logic [COUNT_W-1:0]  run_count,
    input  logic [COUNT_W-1:0]  timeout_cycles,
    input  logic [NUM_CH-1:0]   ch_enable,
    axi_txn_scheduler_if.master eng,
    output logic                busy,
    output logic                run_done,
    output logic                fail,
    output logic                timeout_flag,
    output logic [COUNT_W-1:0]  pass_count,
    output logic [COUNT_W-1:0]  err_count,
    output logic [CH_IDX_W-1:0] last_ch
);

    sched_state_t        state;
    logic [COUNT_W-1:0]  remaining;
    logic [COUNT_W-1:0]  tmo_lim;
    logic [COUNT_W-1:0]  wait_cnt;
    logic [NUM_CH-1:0]   en_mask;
    logic [NUM_CH-1:0]   grant_oh;
    logic [3:0]          pulse_cnt;
    logic [CH_IDX_W-1:0] next_ch;
    logic                done_cur;
    logic                done_q;
    logic                done_edge;
    logic                grant_err;
    logic                tmo_hit;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == '1) ? v : v + COUNT_W'(1);
    endfunction

    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_IDX_W-1:0] idx);
        return NUM_CH'(1) << idx;
    endfunction

    rr_next_sel #(
        .NUM_CH (NUM_CH)
    ) u_rr_next_sel (
        .en_mask  (en_mask),
        .last_idx (last_ch),
        .next_idx (next_ch)
    );

    // Only the granted channel's done/error lines are observed.
    assign done_cur  = |(eng.txn_done & grant_oh);
    assign grant_err = |(eng.txn_error & grant_oh);
    assign done_edge = done_cur & ~done_q;
    assign tmo_hit   = (tmo_lim != '0) && (wait_cnt == tmo_lim - COUNT_W'(1));

    // Registered copy of the granted done level; a level already high when
    // WAIT is entered therefore never looks like an edge.
    always_ff @(posedge ACLK) begin
        done_q <= done_cur;
    end

    // Run sequencer: accept start, arbitrate, pulse, wait, finish.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state            <= ST_IDLE;
            eng.init_axi_txn <= '0;
            busy             <= 1'b0;
            run_done         <= 1'b0;
            fail             <= 1'b0;
            timeout_flag     <= 1'b0;
            pass_count       <= '0;
            err_count        <= '0;
            last_ch          <= CH_IDX_W'(NUM_CH - 1);
            remaining        <= '0;
            tmo_lim          <= '0;
            wait_cnt         <= '0;
            en_mask          <= '0;
            grant_oh         <= '0;
            pulse_cnt        <= '0;
        end else begin
            run_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pass_count   <= '0;
                        err_count    <= '0;
                        fail         <= 1'b0;
                        timeout_flag <= 1'b0;
                        if ((run_count != '0) && (ch_enable != '0)) begin
                            remaining <= run_count;
                            en_mask   <= ch_enable;
                            tmo_lim   <= timeout_cycles;
                            busy      <= 1'b1;
                            state     <= ST_ARB;
                        end else begin
                            run_done <= 1'b1;
                            state    <= ST_FINISH;
                        end
                    end
                end
                ST_ARB: begin
                    grant_oh         <= onehot(next_ch);
                    last_ch          <= next_ch;
                    eng.init_axi_txn <= onehot(next_ch);
                    pulse_cnt        <= '0;
                    state            <= ST_PULSE;
                end
                ST_PULSE: begin
                    if (pulse_cnt == 4'(INIT_PULSE_CYCLES - 1)) begin
                        eng.init_axi_txn <= '0;
                        wait_cnt         <= '0;
                        state            <= ST_WAIT;
                    end else begin
                        pulse_cnt <= pulse_cnt + 4'd1;
                    end
                end
                ST_WAIT: begin
                    // A done edge takes priority over a coincident timeout.
                    if (done_edge) begin
                        if (grant_err) begin
                            err_count <= sat_inc(err_count);
                            fail      <= 1'b1;
                        end else begin
                            pass_count <= sat_inc(pass_count);
                        end
                        remaining <= remaining - COUNT_W'(1);
                        if (remaining == COUNT_W'(1)) begin
                            run_done <= 1'b1;
                            state    <= ST_FINISH;
                        end else begin
                            state <= ST_ARB;
                        end
                    end else if (tmo_hit) begin
                        timeout_flag <= 1'b1;
                        err_count    <= sat_inc(err_count);
                        fail         <= 1'b1;
                        remaining    <= '0;
                        run_done     <= 1'b1;
                        state        <= ST_FINISH;
                    end else begin
                        wait_cnt <= wait_cnt + COUNT_W'(1);
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_txn_scheduler.sv
// Randomized bench for axi_txn_scheduler against a transaction-level model.
module tb_axi_txn_scheduler;
    import axi_txn_sched_pkg::*;

    localparam int NUM_CH = 2;
    localparam int PW     = 2;

    logic                ACLK = 1'b0;
    logic                ARESETN;
    logic                start;
    logic [COUNT_W-1:0]  run_count;
    logic [COUNT_W-1:0]  timeout_cycles;
    logic [NUM_CH-1:0]   ch_enable;
    logic                busy;
    logic                run_done;
    logic                fail;
    logic                timeout_flag;
    logic [COUNT_W-1:0]  pass_count;
    logic [COUNT_W-1:0]  err_count;
    logic [CH_IDX_W-1:0] last_ch;

    int n_checks   = 0;
    int n_errors   = 0;
    int model_last = NUM_CH - 1;

    axi_txn_scheduler_if #(.NUM_CH(NUM_CH)) eng_if();

    axi_txn_scheduler #(
        .NUM_CH            (NUM_CH),
        .INIT_PULSE_CYCLES (PW)
    ) dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .start          (start),
        .run_count      (run_count),
        .timeout_cycles (timeout_cycles),
        .ch_enable      (ch_enable),
        .eng            (eng_if),
        .busy           (busy),
        .run_done       (run_done),
        .fail           (fail),
        .timeout_flag   (timeout_flag),
        .pass_count     (pass_count),
        .err_count      (err_count),
        .last_ch        (last_ch)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #800000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
    endtask

    // Round-robin rule: first enabled channel after the last grant, wrapping.
    function automatic int rr_model(input logic [NUM_CH-1:0] m);
        int c;
        for (int off = 1; off <= NUM_CH; off++) begin
            c = (model_last + off) % NUM_CH;
            if (m[c[0]]) return c;
        end
        return -1;
    endfunction

    // Wait for an init pulse, report its channel and width; ends on the
    // first cycle with init low again (first WAIT cycle).
    task automatic wait_init(output int ch, output int width, output bit ok);
        int cnt;
        logic [NUM_CH-1:0] pat;
        cnt = 0;
        while (eng_if.init_axi_txn == '0 && cnt < 50) begin
            tick();
            cnt++;
        end
        ok  = (eng_if.init_axi_txn != '0);
        pat = eng_if.init_axi_txn;
        if (pat == 2'b01) ch = 0;
        else if (pat == 2'b10) ch = 1;
        else ch = 99;
        width = 0;
        while (ok && eng_if.init_axi_txn == pat && width < 20) begin
            tick();
            width++;
        end
        chk("init_gap", 32'(eng_if.init_axi_txn), 32'(0));
    endtask

    // One run: rc transactions on mask; errs bit t marks txn t as erroring;
    // stall_at = txn whose engine never answers; rst_at = txn whose WAIT gets reset.
    task automatic do_run(input int rc, input logic [NUM_CH-1:0] mask, input int tmo,
                          input logic [15:0] errs, input int stall_at, input int rst_at);
        int exp_pass, exp_err, exp_ch, ch, width, cnt, d;
        bit ok, expect_to, eb;
        logic [NUM_CH-1:0] e;
        exp_pass  = 0;
        exp_err   = 0;
        expect_to = 0;
        start          = 1'b1;
        run_count      = 16'(rc);
        ch_enable      = mask;
        timeout_cycles = 16'(tmo);
        tick();
        start     = 1'b0;
        run_count = 16'($urandom);
        ch_enable = 2'($urandom);
        chk("run_busy", 32'(busy), 32'(1));
        chk("run_clr", 32'({pass_count, err_count}), 32'(0));
        chk("run_fclr", 32'({fail, timeout_flag, run_done}), 32'(0));
        for (int t = 0; t < rc; t++) begin
            exp_ch = rr_model(mask);
            wait_init(ch, width, ok);
            chk("init_seen", 32'(ok), 32'(1));
            chk("grant_ch", ch, exp_ch);
            chk("pulse_w", width, PW);
            model_last = exp_ch;
            if (t == rst_at) begin
                tick();
                ARESETN = 1'b0;
                #1;
                chk("rst_busy", 32'({busy, run_done, fail, timeout_flag}), 32'(0));
                chk("rst_init", 32'(eng_if.init_axi_txn), 32'(0));
                chk("rst_cnt", 32'({pass_count, err_count}), 32'(0));
                chk("rst_last", 32'(last_ch), NUM_CH - 1);
                for (int i = 0; i < 3; i++) begin
                    tick();
                    chk("rst_nodone", 32'(run_done), 32'(0));
                end
                ARESETN = 1'b1;
                tick();
                chk("rel_busy", 32'({busy, run_done}), 32'(0));
                model_last = NUM_CH - 1;
                return;
            end
            if (t == stall_at) begin
                cnt = 0;
                while (!run_done && cnt < tmo + 20) begin
                    chk("to_early", 32'(timeout_flag), 32'(0));
                    tick();
                    cnt++;
                end
                chk("to_lat", cnt, tmo);
                chk("to_flag", 32'(timeout_flag), 32'(1));
                exp_err++;
                expect_to = 1;
                break;
            end
            eng_if.txn_done[~exp_ch[0]] = 1'b1;
            d = $urandom % 4;
            for (int i = 0; i < d; i++) begin
                start     = ($urandom % 3 == 0);
                run_count = 16'($urandom);
                ch_enable = 2'($urandom);
                tick();
            end
            start = 1'b0;
            eb = errs[t[3:0]];
            e  = 2'($urandom);
            e[exp_ch[0]] = eb;
            eng_if.txn_done = '0;
            eng_if.txn_done[exp_ch[0]] = 1'b1;
            eng_if.txn_error = e;
            tick();
            eng_if.txn_done  = '0;
            eng_if.txn_error = '0;
            if (eb) exp_err++;
            else exp_pass++;
        end
        cnt = 0;
        while (!run_done && cnt < 10) begin
            tick();
            cnt++;
        end
        chk("rd_seen", 32'(run_done), 32'(1));
        chk("pass_cnt", 32'(pass_count), exp_pass);
        chk("err_cnt", 32'(err_count), exp_err);
        chk("fail", 32'(fail), 32'((exp_err != 0) || expect_to));
        chk("tflag", 32'(timeout_flag), 32'(expect_to));
        chk("last_ch", 32'(last_ch), model_last);
        tick();
        chk("busy_drop", 32'(busy), 32'(0));
        chk("rd_single", 32'(run_done), 32'(0));
        chk("fail_hold", 32'(fail), 32'((exp_err != 0) || expect_to));
    endtask

    // Degenerate start (zero count or no channel): straight to FINISH.
    task automatic do_zero(input int rc, input logic [NUM_CH-1:0] mask);
        int cnt;
        start          = 1'b1;
        run_count      = 16'(rc);
        ch_enable      = mask;
        timeout_cycles = '0;
        tick();
        start = 1'b0;
        cnt   = 1;
        while (!run_done && cnt < 4) begin
            chk("zero_noinit", 32'(eng_if.init_axi_txn), 32'(0));
            tick();
            cnt++;
        end
        chk("zero_rd", 32'(run_done), 32'(1));
        chk("zero_lat", 32'(cnt <= 2), 32'(1));
        chk("zero_cnt", 32'({pass_count, err_count}), 32'(0));
        chk("zero_fail", 32'({fail, timeout_flag}), 32'(0));
        chk("zero_last", 32'(last_ch), model_last);
        tick();
        chk("zero_busy", 32'({busy, run_done}), 32'(0));
        chk("zero_noinit2", 32'(eng_if.init_axi_txn), 32'(0));
    endtask

    initial begin
        int rc, tmo, stall;
        logic [NUM_CH-1:0] mask;
        ARESETN          = 1'b0;
        start            = 1'b0;
        run_count        = '0;
        timeout_cycles   = '0;
        ch_enable        = '0;
        eng_if.txn_done  = '0;
        eng_if.txn_error = '0;
        repeat (3) tick();
        chk("por_ctl", 32'({busy, run_done, fail, timeout_flag}), 32'(0));
        chk("por_cnt", 32'({pass_count, err_count}), 32'(0));
        chk("por_init", 32'(eng_if.init_axi_txn), 32'(0));
        chk("por_last", 32'(last_ch), NUM_CH - 1);
        ARESETN = 1'b1;
        tick();

        do_run(4, 2'b11, 0, 16'h0000, -1, -1);
        do_run(3, 2'b10, 0, 16'b010, -1, -1);
        do_zero(0, 2'b11);
        do_run(2, 2'b11, 50, 16'h0000, 0, -1);
        do_zero(5, 2'b00);
        eng_if.txn_done = 2'b01;
        do_run(1, 2'b01, 20, 16'h0000, 0, -1);
        eng_if.txn_done = '0;
        tick();
        do_run(4, 2'b11, 0, 16'h0000, -1, 1);
        do_run(2, 2'b11, 0, 16'h0001, -1, -1);

        for (int r = 0; r < 8; r++) begin
            rc    = 1 + ($urandom % 6);
            mask  = 2'(1 + ($urandom % 3));
            tmo   = ($urandom % 2 == 0) ? 0 : 20 + int'($urandom % 20);
            stall = (tmo != 0 && $urandom % 3 == 0) ? int'($urandom % rc) : -1;
            do_run(rc, mask, tmo, 16'($urandom), stall, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
